// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// Holds the FSM state encoding and the data width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    WAIT_HIGH
  } uart_arb_state_t;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the arbiter.
// The slave modport is the arbiter; master is its environment.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
) ();
  import uart_pkg::*;

  localparam int IDW = idw(NUM_REQ);

  logic [NUM_REQ-1:0]             Req;
  logic [NUM_REQ*UART_DATA_W-1:0] Data;
  logic [NUM_REQ-1:0]             Ack;
  logic [NUM_REQ-1:0]             Done;
  logic                           Error;
  logic                           Busy;
  logic [IDW-1:0]                 Grant_Id;
  logic [UART_DATA_W-1:0]         TX_Data;
  logic                           TX_Start;
  logic                           TX_EOT;

  modport slave (
    input  Req, Data, TX_EOT,
    output Ack, Done, Error, Busy,
    output Grant_Id, TX_Data, TX_Start
  );

  modport master (
    output Req, Data, TX_EOT,
    input  Ack, Done, Error, Busy,
    input  Grant_Id, TX_Data, TX_Start
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: search starts just above ptr.
// Rotate, take the lowest set bit, then map back to an index.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] Req,
  input  logic [IDW-1:0]     ptr,
  output logic               Valid,
  output logic [IDW-1:0]     Winner
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   off;
  int                   sum;

  always_comb begin
    dbl = {Req, Req};
    rot = NUM_REQ'(dbl >> (int'(ptr) + 1));
    off = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = int'(ptr) + 1 + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    Valid  = |Req;
    Winner = IDW'(sum);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte requesters, round-robin.
// Tracks EOT over the frame and reports Done or a start timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int FREQ_CLK      = 100_000_000,
  parameter int START_TIMEOUT = 16
) (
  input logic              Clk,
  input logic              Rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDW = idw(NUM_REQ);
  localparam int CW  = $clog2(START_TIMEOUT + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be 2..8");
  end
  if (FREQ_CLK <= 0) begin : g_bad_freq
    $error("FREQ_CLK must be positive");
  end

  uart_arb_state_t        state_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [IDW-1:0]         ptr_q;
  logic [IDW-1:0]         grant_q;
  logic [UART_DATA_W-1:0] txd_q;
  logic                   start_q;
  logic [NUM_REQ-1:0]     ack_q;
  logic [NUM_REQ-1:0]     done_q;
  logic                   err_q;
  logic                   valid;
  logic [IDW-1:0]         winner;

  uart_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_rr (
    .Req   (bus.Req),
    .ptr   (ptr_q),
    .Valid (valid),
    .Winner(winner)
  );

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= IDW'(NUM_REQ - 1);
      grant_q <= '0;
      txd_q   <= '0;
      start_q <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // EOT low here means uart_tx is busy with someone else's frame
          if (bus.TX_EOT && valid) begin
            txd_q <= bus.Data[int'(winner)*UART_DATA_W +: UART_DATA_W];
            start_q        <= 1'b1;
            ack_q[winner]  <= 1'b1;
            grant_q        <= winner;
            ptr_q          <= winner;
            cnt_q          <= '0;
            state_q        <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!bus.TX_EOT) begin
            state_q <= WAIT_HIGH;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CW'(START_TIMEOUT)) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          if (bus.TX_EOT) begin
            done_q[grant_q] <= 1'b1;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Ack      = ack_q;
  assign bus.Done     = done_q;
  assign bus.Error    = err_q;
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Grant_Id = grant_q;
  assign bus.TX_Data  = txd_q;
  assign bus.TX_Start = start_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` serializer between `NUM_REQ` byte requesters (e.g. CPU port, DMA, debug monitor). It grants one requester at a time, captures its byte, and drives `Start`/`Data` into `uart_tx`. It then tracks `uart_tx`'s `EOT` through the whole frame and reports completion or a start failure to the granted requester. It sits between the requesters and the `uart_tx` instance in the UART subsystem.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `FREQ_CLK`, 100000000: system clock frequency in Hz. Passed through for documentation only; no arithmetic depends on it.
- `START_TIMEOUT`, 16: cycles to wait for `TX_EOT` to fall after `TX_Start` before declaring an error.
- `Clk`  in  1: system clock; all state updates on the rising edge.
- `Rst`  in  1: asynchronous, active-high reset.
- `Req`  in  `NUM_REQ`: per-requester request level. Held high, with `Data` stable, until `Ack`.
- `Data`  in  `NUM_REQ*8`: flattened bytes; requester i owns bits `[8*i+7:8*i]`.
- `Ack`  out  `NUM_REQ`: one-cycle pulse; the byte of requester i has been captured.
- `Done`  out  `NUM_REQ`: one-cycle pulse; the frame of requester i has finished (stop bit sent).
- `Error`  out  1: one-cycle pulse on start timeout.
- `Busy`  out  1: high whenever the FSM is not IDLE.
- `Grant_Id`  out  `$clog2(NUM_REQ)` (min 1): index of the current or last granted requester.
- `TX_Data`  out  8: byte to `uart_tx` `Data`.
- `TX_Start`  out  1: one-cycle start pulse to `uart_tx` `Start`.
- `TX_EOT`  in  1: `uart_tx` `EOT`. It is high when idle, falls after `Start` is accepted, and rises at the end of the stop bit.

## Operation
- FSM states: IDLE, WAIT_LOW, WAIT_HIGH.
- **IDLE:** when `TX_EOT`=1 and `|Req`, the arbiter picks a winner w by round-robin, searching from `ptr+1` upward and wrapping at `NUM_REQ`. On that edge it registers:
  - `TX_Data` ← `Data[w]`
  - `TX_Start` ← 1
  - `Ack[w]` ← 1
  - `Grant_Id` ← w
  - `ptr` ← w
  - state ← WAIT_LOW, timeout counter ← 0
- **IDLE with `TX_EOT`=0** (`uart_tx` still busy from an external source or after reset): no grant.
- **WAIT_LOW:**
  - `TX_Start` and `Ack` clear on the first edge after they are set.
  - If `TX_EOT`=0, go to WAIT_HIGH.
  - Otherwise increment the counter. When it reaches `START_TIMEOUT`, pulse `Error` and go to IDLE with no `Done`. The byte is dropped and is not retried.
- **WAIT_HIGH:** when `TX_EOT`=1, pulse `Done[Grant_Id]` and go to IDLE.
- `TX_Data` holds its value until the next grant.
- A requester that drops `Req` before `Ack` is simply not granted. A requester whose `Req` stays high after `Ack` gets a new grant only in round-robin order.
- Reset mid-frame: the FSM returns to IDLE immediately. `uart_tx` is reset by the same `Rst`, so no frame is in flight after reset.

## Timing
- Reset values: `TX_Start`=0, `TX_Data`=0x00, `Ack`=0, `Done`=0, `Error`=0, `Busy`=0, `Grant_Id`=0, `ptr`=`NUM_REQ-1` (so requester 0 wins first).
- Grant latency: `Ack` and `TX_Start` are high in the cycle after the IDLE edge that samples `Req`. Both are high for exactly the same single cycle.
- `Done` is high for one cycle, in the cycle after the edge that samples `TX_EOT`=1 in WAIT_HIGH. `Busy` is 0 in that same cycle.
- Back-to-back: the next grant can happen on the edge following `Done`. The minimum spacing between `TX_Start` pulses is therefore frame length + 2 cycles.
- Simultaneous requests: exactly one `Ack` bit is ever high at a time. `Ack`, `Done` and `Error` are never high in the same cycle.

## Structure
- Shared package `uart_pkg`: `uart_arb_state_t` enum (IDLE, WAIT_LOW, WAIT_HIGH) and `localparam UART_DATA_W = 8`.
- One sub-module, `uart_rr_arbiter`:
  - inputs `Req` and `ptr`; outputs `Valid` and `Winner`;
  - purely combinational rotate / priority-encode / unrotate.
  - The FSM, counter, pointer and output registers live in `uart_tx_arbiter`.

## Test plan
- **Single request:** `NUM_REQ`=2, after reset pulse `Req[0]` with `Data[0]`=0xAA → one cycle later `Ack`=01, `TX_Start`=1, `TX_Data`=0xAA. `TXD` (from `uart_tx`) shows 0xAA LSB-first. `Done`=01 one cycle after `EOT` rises.
- **Contention:** `Req`=11 held continuously, `Data`=0x03/0xCC → grants alternate 0,1,0,1. Bytes appear on `TXD` in order 0x03, 0xCC, 0x03, 0xCC. `TX_Start` pulses are spaced by frame length + 2 cycles.
- **Request withdrawal:** `Req[1]` high for 1 cycle while requester 0's frame is in WAIT_HIGH → no `Ack[1]`, no second frame.
- **Start timeout:** replace `uart_tx` with a model holding `EOT`=1 and pulse `Req[0]` → `Error` pulse exactly 16 cycles after WAIT_LOW entry, no `Done`, `Busy` returns to 0.
- **Reset mid-frame:** assert `Rst` during WAIT_HIGH → all outputs at reset values in the same cycle. After release, `Req`=11 grants requester 0 first.
- **Busy UART at idle:** `TX_EOT` forced 0 while `Req`=01 → no grant until `TX_EOT`=1, then `Ack` one cycle later.
